// File: rtl/regfile_sb.sv
// regfile_sb: parametrised register file with two prioritised write ports,
// optional write-to-read bypass and a per-register busy scoreboard.
module regfile_sb #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [NUM_RD*ADDR_W-1:0]   i_ra,
  output logic [NUM_RD*DATA_W-1:0]   o_rd,
  output logic [NUM_RD-1:0]          o_rd_busy,
  input  logic                       i_we0,
  input  logic [ADDR_W-1:0]          i_wa0,
  input  logic [DATA_W-1:0]          i_wd0,
  input  logic                       i_we1,
  input  logic [ADDR_W-1:0]          i_wa1,
  input  logic [DATA_W-1:0]          i_wd1,
  input  logic                       i_issue,
  input  logic [ADDR_W-1:0]          i_issue_addr,
  input  logic                       i_flush,
  output logic [ADDR_W:0]            o_busy_cnt
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam bit ZR = (ZERO_REG != 0);
  localparam bit BP = (BYPASS != 0);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;

  // Writes that actually land in the array (entry 0 is hardwired when ZR).
  logic we0_eff, we1_eff, iss_eff;
  assign we0_eff = i_we0 && !(ZR && i_wa0 == '0);
  assign we1_eff = i_we1 && !(ZR && i_wa1 == '0);
  assign iss_eff = i_issue && !(ZR && i_issue_addr == '0);

  // Array next state: port 1 applied last so it wins on an address clash.
  always_comb begin
    mem_d = mem_q;
    if (we0_eff) mem_d[i_wa0] = i_wd0;
    if (we1_eff) mem_d[i_wa1] = i_wd1;
  end

  // Scoreboard next state: flush, then new producer, then writeback clear.
  always_comb begin
    busy_d = busy_q;
    cnt_d  = '0;
    for (int e = 0; e < DEPTH; e++) begin
      if (i_flush)
        busy_d[e] = 1'b0;
      else if (iss_eff && i_issue_addr == ADDR_W'(e))
        busy_d[e] = 1'b1;
      else if ((we0_eff && i_wa0 == ADDR_W'(e)) ||
               (we1_eff && i_wa1 == ADDR_W'(e)))
        busy_d[e] = 1'b0;
      if (ZR && e == 0)
        busy_d[e] = 1'b0;
      cnt_d = cnt_d + (ADDR_W+1)'(busy_d[e]);
    end
  end

  // State registers; count tracks the popcount of the busy vector.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int e = 0; e < DEPTH; e++) mem_q[e] <= '0;
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      for (int e = 0; e < DEPTH; e++) mem_q[e] <= mem_d[e];
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign o_busy_cnt = cnt_q;

  // Read ports: stored value, overridden by same-cycle writes when bypassing.
  always_comb begin
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd;
    logic              bsy;
    logic              hit0, hit1;
    o_rd      = '0;
    o_rd_busy = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      ra   = i_ra[k*ADDR_W +: ADDR_W];
      rd   = mem_q[ra];
      bsy  = busy_q[ra];
      hit1 = BP && i_we1 && i_wa1 == ra;
      hit0 = BP && i_we0 && i_wa0 == ra;
      if (hit1)
        rd = i_wd1;
      else if (hit0)
        rd = i_wd0;
      if (hit0 || hit1)
        bsy = 1'b0;
      if (ZR && ra == '0) begin
        rd  = '0;
        bsy = 1'b0;
      end
      o_rd[k*DATA_W +: DATA_W] = rd;
      o_rd_busy[k]             = bsy;
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed vector table plus hand sequences and a
// scoreboard-model random phase for regfile_sb.
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        rstn;
  logic [9:0]  i_ra;
  logic [63:0] o_rd, nb_rd;
  logic [1:0]  o_rd_busy, nb_busy;
  logic        i_we0, i_we1, i_issue, i_flush;
  logic [4:0]  i_wa0, i_wa1, i_issue_addr;
  logic [31:0] i_wd0, i_wd1;
  logic [5:0]  o_busy_cnt, nb_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  regfile_sb dut (
    .clk(clk), .rstn(rstn), .i_ra(i_ra), .o_rd(o_rd),
    .o_rd_busy(o_rd_busy), .i_we0(i_we0), .i_wa0(i_wa0),
    .i_wd0(i_wd0), .i_we1(i_we1), .i_wa1(i_wa1), .i_wd1(i_wd1),
    .i_issue(i_issue), .i_issue_addr(i_issue_addr),
    .i_flush(i_flush), .o_busy_cnt(o_busy_cnt)
  );

  regfile_sb #(.ZERO_REG(0), .BYPASS(0)) u_nb (
    .clk(clk), .rstn(rstn), .i_ra(i_ra), .o_rd(nb_rd),
    .o_rd_busy(nb_busy), .i_we0(i_we0), .i_wa0(i_wa0),
    .i_wd0(i_wd0), .i_we1(i_we1), .i_wa1(i_wa1), .i_wd1(i_wd1),
    .i_issue(i_issue), .i_issue_addr(i_issue_addr),
    .i_flush(i_flush), .o_busy_cnt(nb_cnt)
  );

  typedef struct {
    logic        we0; logic [4:0] wa0; logic [31:0] wd0;
    logic        we1; logic [4:0] wa1; logic [31:0] wd1;
    logic        iss; logic [4:0] ia;  logic        fl;
    logic [4:0]  ra0; logic [4:0] ra1;
    logic [31:0] e_rd0; logic [31:0] e_rd1;
    logic        e_b0;  logic        e_b1;
    logic [5:0]  e_cnt;
  } vec_t;

  vec_t tbl [18];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    i_we0 = 1'b0; i_wa0 = '0; i_wd0 = '0;
    i_we1 = 1'b0; i_wa1 = '0; i_wd1 = '0;
    i_issue = 1'b0; i_issue_addr = '0; i_flush = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic       mb [32];
  int         mcnt;
  logic [4:0] r0;
  logic       eb;

  initial begin
    tbl[0]  = '{1'b0,5'd0,32'h0,1'b0,5'd0,32'h0,1'b0,5'd0,1'b0,5'd0,5'd31,32'h0,32'h0,1'b0,1'b0,6'd0};
    tbl[1]  = '{1'b1,5'd5,32'hDEADBEEF,1'b0,5'd0,32'h0,1'b0,5'd0,1'b0,5'd5,5'd5,32'hDEADBEEF,32'hDEADBEEF,1'b0,1'b0,6'd0};
    tbl[2]  = '{1'b0,5'd0,32'h0,1'b0,5'd0,32'h0,1'b0,5'd0,1'b0,5'd5,5'd7,32'hDEADBEEF,32'h0,1'b0,1'b0,6'd0};
    tbl[3]  = '{1'b1,5'd7,32'h11111111,1'b1,5'd7,32'h22222222,1'b0,5'd0,1'b0,5'd7,5'd5,32'h22222222,32'hDEADBEEF,1'b0,1'b0,6'd0};
    tbl[4]  = '{1'b0,5'd0,32'h0,1'b0,5'd0,32'h0,1'b0,5'd0,1'b0,5'd7,5'd5,32'h22222222,32'hDEADBEEF,1'b0,1'b0,6'd0};
    tbl[5]  = '{1'b0,5'd0,32'h0,1'b1,5'd0,32'hFFFFFFFF,1'b0,5'd0,1'b0,5'd0,5'd0,32'h0,32'h0,1'b0,1'b0,6'd0};
    tbl[6]  = '{1'b0,5'd0,32'h0,1'b0,5'd0,32'h0,1'b0,5'd0,1'b0,5'd0,5'd7,32'h0,32'h22222222,1'b0,1'b0,6'd0};
    tbl[7]  = '{1'b0,5'd0,32'h0,1'b0,5'd0,32'h0,1'b1,5'd3,1'b0,5'd3,5'd4,32'h0,32'h0,1'b0,1'b0,6'd1};
    tbl[8]  = '{1'b0,5'd0,32'h0,1'b0,5'd0,32'h0,1'b1,5'd4,1'b0,5'd3,5'd4,32'h0,32'h0,1'b1,1'b0,6'd2};
    tbl[9]  = '{1'b0,5'd0,32'h0,1'b0,5'd0,32'h0,1'b1,5'd9,1'b0,5'd4,5'd9,32'h0,32'h0,1'b1,1'b0,6'd3};
    tbl[10] = '{1'b1,5'd4,32'h44,1'b0,5'd0,32'h0,1'b0,5'd0,1'b0,5'd4,5'd3,32'h44,32'h0,1'b0,1'b1,6'd2};
    tbl[11] = '{1'b0,5'd0,32'h0,1'b0,5'd0,32'h0,1'b0,5'd0,1'b0,5'd4,5'd9,32'h44,32'h0,1'b0,1'b1,6'd2};
    tbl[12] = '{1'b0,5'd0,32'h0,1'b1,5'd6,32'h66,1'b1,5'd6,1'b0,5'd6,5'd3,32'h66,32'h0,1'b0,1'b1,6'd3};
    tbl[13] = '{1'b0,5'd0,32'h0,1'b0,5'd0,32'h0,1'b0,5'd0,1'b0,5'd6,5'd9,32'h66,32'h0,1'b1,1'b1,6'd3};
    tbl[14] = '{1'b0,5'd0,32'h0,1'b0,5'd0,32'h0,1'b1,5'd8,1'b1,5'd8,5'd3,32'h0,32'h0,1'b0,1'b1,6'd0};
    tbl[15] = '{1'b0,5'd0,32'h0,1'b0,5'd0,32'h0,1'b0,5'd0,1'b0,5'd8,5'd3,32'h0,32'h0,1'b0,1'b0,6'd0};
    tbl[16] = '{1'b0,5'd0,32'h0,1'b0,5'd0,32'h0,1'b1,5'd0,1'b0,5'd0,5'd3,32'h0,32'h0,1'b0,1'b0,6'd0};
    tbl[17] = '{1'b0,5'd0,32'h0,1'b0,5'd0,32'h0,1'b0,5'd0,1'b0,5'd0,5'd6,32'h0,32'h66,1'b0,1'b0,6'd0};

    idle();
    i_ra = '0;
    rstn = 1'b0;
    #12;
    for (int a = 0; a < 32; a++) begin
      i_ra = {a[4:0], a[4:0]};
      #1;
      chk($sformatf("rst_rd a%0d", a), o_rd[31:0] | o_rd[63:32], 32'h0);
      chk($sformatf("rst_busy a%0d", a), {30'h0, o_rd_busy}, 32'h0);
    end
    chk("rst_cnt", {26'h0, o_busy_cnt}, 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    tick();

    for (int i = 0; i < 18; i++) begin
      i_we0 = tbl[i].we0; i_wa0 = tbl[i].wa0; i_wd0 = tbl[i].wd0;
      i_we1 = tbl[i].we1; i_wa1 = tbl[i].wa1; i_wd1 = tbl[i].wd1;
      i_issue = tbl[i].iss; i_issue_addr = tbl[i].ia;
      i_flush = tbl[i].fl;
      i_ra = {tbl[i].ra1, tbl[i].ra0};
      #1;
      chk($sformatf("v%0d rd0", i), o_rd[31:0], tbl[i].e_rd0);
      chk($sformatf("v%0d rd1", i), o_rd[63:32], tbl[i].e_rd1);
      chk($sformatf("v%0d busy", i), {30'h0, o_rd_busy},
          {30'h0, tbl[i].e_b1, tbl[i].e_b0});
      tick();
      idle();
      chk($sformatf("v%0d cnt", i), {26'h0, o_busy_cnt},
          {26'h0, tbl[i].e_cnt});
    end

    // Unbypassed instance: old value in the write cycle, new one after.
    i_we0 = 1'b1; i_wa0 = 5'd5; i_wd0 = 32'hCAFEF00D;
    i_ra = {5'd5, 5'd5};
    #1;
    chk("byp_rd", o_rd[31:0], 32'hCAFEF00D);
    chk("nb_old_rd", nb_rd[31:0], 32'hDEADBEEF);
    tick();
    idle();
    chk("nb_new_rd", nb_rd[31:0], 32'hCAFEF00D);

    // Entry 0 behaves as a normal register without ZERO_REG.
    i_ra = {5'd0, 5'd0};
    #1;
    chk("nb_r0", nb_rd[31:0], 32'hFFFFFFFF);
    chk("zr_r0", o_rd[31:0], 32'h0);
    chk("nb_cnt_r0", {26'h0, nb_cnt}, 32'd1);

    // Writeback clears busy same cycle only with bypass.
    i_issue = 1'b1; i_issue_addr = 5'd10;
    tick();
    idle();
    i_we1 = 1'b1; i_wa1 = 5'd10; i_wd1 = 32'h10;
    i_ra = {5'd10, 5'd10};
    #1;
    chk("wb_busy_byp", {31'h0, o_rd_busy[0]}, 32'd0);
    chk("wb_busy_nb", {31'h0, nb_busy[0]}, 32'd1);
    tick();
    idle();

    // Asynchronous reset mid-cycle clears state before the next edge.
    i_issue = 1'b1; i_issue_addr = 5'd11;
    tick();
    idle();
    i_ra = {5'd11, 5'd5};
    #1;
    chk("pre_rst_busy", {31'h0, o_rd_busy[1]}, 32'd1);
    chk("pre_rst_cnt", {26'h0, o_busy_cnt}, 32'd1);
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_rd", o_rd[31:0], 32'h0);
    chk("arst_busy", {30'h0, o_rd_busy}, 32'h0);
    chk("arst_cnt", {26'h0, o_busy_cnt}, 32'h0);
    chk("arst_nb_cnt", {26'h0, nb_cnt}, 32'h0);
    #2;
    rstn = 1'b1;
    tick();

    // Random issue/write/flush against a scoreboard model.
    for (int e = 0; e < 32; e++) mb[e] = 1'b0;
    mcnt = 0;
    for (int c = 0; c < 10000; c++) begin
      i_we0 = 1'($urandom_range(1));
      i_wa0 = 5'($urandom);
      i_wd0 = $urandom;
      i_we1 = 1'($urandom_range(1));
      i_wa1 = 5'($urandom);
      i_wd1 = $urandom;
      i_issue = 1'($urandom_range(1));
      i_issue_addr = 5'($urandom);
      i_flush = ($urandom_range(31) == 0);
      r0 = 5'($urandom);
      i_ra = {5'd0, r0};
      #1;
      eb = mb[r0] && r0 != 0 && !(i_we0 && i_wa0 == r0)
           && !(i_we1 && i_wa1 == r0);
      chk($sformatf("rnd%0d busy", c), {31'h0, o_rd_busy[0]},
          {31'h0, eb});
      mcnt = 0;
      for (int e = 1; e < 32; e++) begin
        if (i_flush) mb[e] = 1'b0;
        else if (i_issue && i_issue_addr == 5'(e)) mb[e] = 1'b1;
        else if ((i_we0 && i_wa0 == 5'(e)) ||
                 (i_we1 && i_wa1 == 5'(e))) mb[e] = 1'b0;
        if (mb[e]) mcnt++;
      end
      tick();
      chk($sformatf("rnd%0d cnt", c), {26'h0, o_busy_cnt}, 32'(mcnt));
    end
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
